// File: rtl/sc_level_sequencer.sv
// sc_level_sequencer: game-flow FSM sequencing clear, level banner, layout load and play for the 8x8 matrix game
//   SC_LEVELSEQ_CLOCK_50           in   clock
//   SC_LEVELSEQ_RESET_InHigh       in   async active-high reset
//   SC_LEVELSEQ_start_InLow        in   start/restart request (sampled in IDLE/WIN/GAMEOVER)
//   SC_LEVELSEQ_levelDone_InLow    in   level cleared (sampled in PLAY)
//   SC_LEVELSEQ_gameOver_InLow     in   player lost (sampled in PLAY)
//   SC_LEVELSEQ_transition_OutBUS  out  pattern code: 0 = gameplay layout, 1..MAX_LEVEL = banner
//   SC_LEVELSEQ_clear_OutLow       out  register-bank clear strobe
//   SC_LEVELSEQ_load_OutLow        out  register-bank load strobe
//   SC_LEVELSEQ_level_OutBUS       out  current level
//   SC_LEVELSEQ_playEnable_Out     out  high in PLAY
//   SC_LEVELSEQ_win_Out            out  high in WIN
//   SC_LEVELSEQ_gameOver_Out       out  high in GAMEOVER
module sc_level_sequencer #(
    parameter int BANNER_CYCLES = 50000000,
    parameter int CNT_W         = 26,
    parameter int MAX_LEVEL     = 4
) (
    input  logic       SC_LEVELSEQ_CLOCK_50,
    input  logic       SC_LEVELSEQ_RESET_InHigh,
    input  logic       SC_LEVELSEQ_start_InLow,
    input  logic       SC_LEVELSEQ_levelDone_InLow,
    input  logic       SC_LEVELSEQ_gameOver_InLow,
    output logic [2:0] SC_LEVELSEQ_transition_OutBUS,
    output logic       SC_LEVELSEQ_clear_OutLow,
    output logic       SC_LEVELSEQ_load_OutLow,
    output logic [2:0] SC_LEVELSEQ_level_OutBUS,
    output logic       SC_LEVELSEQ_playEnable_Out,
    output logic       SC_LEVELSEQ_win_Out,
    output logic       SC_LEVELSEQ_gameOver_Out
);
    typedef enum logic [2:0] {IDLE, CLEAR, BANNER, LOAD, PLAY, WIN, GAMEOVER} state_t;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BANNER_CYCLES - 1);
    localparam logic [2:0]       MAX_L = 3'(MAX_LEVEL);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Outputs are registered alongside the next state so each one is valid for the whole cycle of its state.
    always_ff @(posedge SC_LEVELSEQ_CLOCK_50 or posedge SC_LEVELSEQ_RESET_InHigh) begin
        if (SC_LEVELSEQ_RESET_InHigh) begin
            state                         <= IDLE;
            cnt                           <= '0;
            SC_LEVELSEQ_level_OutBUS      <= 3'd1;
            SC_LEVELSEQ_transition_OutBUS <= 3'd0;
            SC_LEVELSEQ_clear_OutLow      <= 1'b1;
            SC_LEVELSEQ_load_OutLow       <= 1'b1;
            SC_LEVELSEQ_playEnable_Out    <= 1'b0;
            SC_LEVELSEQ_win_Out           <= 1'b0;
            SC_LEVELSEQ_gameOver_Out      <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN, GAMEOVER: if (!SC_LEVELSEQ_start_InLow) begin
                    state                         <= CLEAR;
                    cnt                           <= '0;
                    SC_LEVELSEQ_level_OutBUS      <= 3'd1;
                    SC_LEVELSEQ_transition_OutBUS <= 3'd1;
                    SC_LEVELSEQ_clear_OutLow      <= 1'b0;
                    SC_LEVELSEQ_win_Out           <= 1'b0;
                    SC_LEVELSEQ_gameOver_Out      <= 1'b0;
                end
                CLEAR: begin
                    state                    <= BANNER;
                    cnt                      <= '0;
                    SC_LEVELSEQ_clear_OutLow <= 1'b1;
                end
                BANNER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state                         <= LOAD;
                        SC_LEVELSEQ_transition_OutBUS <= 3'd0;
                        SC_LEVELSEQ_load_OutLow       <= 1'b0;
                    end
                end
                LOAD: begin
                    state                      <= PLAY;
                    SC_LEVELSEQ_load_OutLow    <= 1'b1;
                    SC_LEVELSEQ_playEnable_Out <= 1'b1;
                end
                PLAY: if (!SC_LEVELSEQ_gameOver_InLow) begin
                    state                      <= GAMEOVER;
                    SC_LEVELSEQ_playEnable_Out <= 1'b0;
                    SC_LEVELSEQ_gameOver_Out   <= 1'b1;
                end else if (!SC_LEVELSEQ_levelDone_InLow) begin
                    SC_LEVELSEQ_playEnable_Out <= 1'b0;
                    if (SC_LEVELSEQ_level_OutBUS == MAX_L) begin
                        state               <= WIN;
                        SC_LEVELSEQ_win_Out <= 1'b1;
                    end else begin
                        state                         <= CLEAR;
                        cnt                           <= '0;
                        SC_LEVELSEQ_level_OutBUS      <= SC_LEVELSEQ_level_OutBUS + 3'd1;
                        SC_LEVELSEQ_transition_OutBUS <= SC_LEVELSEQ_level_OutBUS + 3'd1;
                        SC_LEVELSEQ_clear_OutLow      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_level_sequencer.sv
// tb_sc_level_sequencer: directed bench with an elapsed-time model of the level sequencer
module tb_sc_level_sequencer;
    localparam int BC   = 4;
    localparam int MAXL = 4;
    logic clk = 0, rst = 1, start = 1, done = 1, gov = 1;
    logic [2:0] tr, lvl_o;
    logic clr, ld, pe, win, go;
    int checks = 0, errors = 0;
    sc_level_sequencer #(.BANNER_CYCLES(BC), .CNT_W(3), .MAX_LEVEL(MAXL)) dut (
        .SC_LEVELSEQ_CLOCK_50(clk),
        .SC_LEVELSEQ_RESET_InHigh(rst),
        .SC_LEVELSEQ_start_InLow(start),
        .SC_LEVELSEQ_levelDone_InLow(done),
        .SC_LEVELSEQ_gameOver_InLow(gov),
        .SC_LEVELSEQ_transition_OutBUS(tr),
        .SC_LEVELSEQ_clear_OutLow(clr),
        .SC_LEVELSEQ_load_OutLow(ld),
        .SC_LEVELSEQ_level_OutBUS(lvl_o),
        .SC_LEVELSEQ_playEnable_Out(pe),
        .SC_LEVELSEQ_win_Out(win),
        .SC_LEVELSEQ_gameOver_Out(go)
    );
    always #5 clk = ~clk;
    // Model: a game is a timeline measured from the edge that started the current level
    // (d=0 clear, 1..BC banner, BC+1 load, >=BC+2 play). mode: 0 idle, 1 running, 2 won, 3 lost.
    int e = 0, t0 = 0, lvl = 1, mode = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mode = 0;
            lvl  = 1;
        end else begin
            e++;
            if (mode != 1) begin
                if (!start) begin
                    mode = 1;
                    lvl  = 1;
                    t0   = e;
                end
            end else if (e - 1 - t0 >= BC + 2) begin
                if (!gov) mode = 3;
                else if (!done) begin
                    if (lvl == MAXL) mode = 2;
                    else begin
                        lvl++;
                        t0 = e;
                    end
                end
            end
        end
    end
    always @(posedge clk) begin
        int d;
        logic [10:0] act, exp_v;
        #1;
        d     = e - t0;
        exp_v = {3'((mode == 1 && d <= BC) ? lvl : 0), !(mode == 1 && d == 0), !(mode == 1 && d == BC + 1),
                 3'(lvl), mode == 1 && d >= BC + 2, mode == 2, mode == 3};
        act   = {tr, clr, ld, lvl_o, pe, win, go};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL outputs t=%0t actual=%03h required=%03h", $time, act, exp_v);
        end
    end
    task automatic chk(input string n, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", n, act, exp_v);
        end
    endtask
    task automatic start_game();
        start = 0;
        @(negedge clk);
        start = 1;
        chk("start_clear", clr, 0);
        chk("start_trans", tr, 1);
        chk("start_level", lvl_o, 1);
        repeat (BC + 1) @(negedge clk);
        chk("load_strobe", ld, 0);
        chk("load_trans", tr, 0);
        @(negedge clk);
        chk("play_en", pe, 1);
    endtask
    task automatic next_level(input int n);
        done = 0;
        @(negedge clk);
        done = 1;
        chk("adv_clear", clr, 0);
        chk("adv_level", lvl_o, n);
        chk("adv_trans", tr, n);
        repeat (BC + 2) @(negedge clk);
        chk("adv_play", pe, 1);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_trans", tr, 0);
        chk("rst_strobes", {clr, ld}, 3);
        rst = 0;
        repeat (20) @(negedge clk);
        chk("idle_level", lvl_o, 1);
        chk("idle_flags", {pe, win, go}, 0);
        start_game();
        next_level(2);
        next_level(3);
        next_level(4);
        done = 0;
        @(negedge clk);
        done = 1;
        chk("win_flag", win, 1);
        chk("win_strobes", {clr, ld}, 3);
        repeat (3) @(negedge clk);
        chk("win_level", lvl_o, 4);
        start_game();
        next_level(2);
        done = 0;
        gov  = 0;
        @(negedge clk);
        done = 1;
        gov  = 1;
        chk("over_flag", go, 1);
        chk("over_level", lvl_o, 2);
        chk("over_play", pe, 0);
        repeat (3) @(negedge clk);
        start = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        done = 0;
        gov  = 0;
        @(negedge clk);
        done = 1;
        gov  = 1;
        repeat (3) @(negedge clk);
        chk("ign_load", ld, 0);
        done = 0;
        gov  = 0;
        @(negedge clk);
        done = 1;
        gov  = 1;
        chk("ign_play", pe, 1);
        chk("ign_level", lvl_o, 1);
        chk("ign_over", go, 0);
        next_level(2);
        done = 0;
        @(negedge clk);
        done = 1;
        repeat (2) @(negedge clk);
        chk("mid_banner_trans", tr, 3);
        rst = 1;
        #1;
        chk("mid_rst_trans", tr, 0);
        chk("mid_rst_level", lvl_o, 1);
        chk("mid_rst_strobes", {clr, ld}, 3);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        start_game();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
